// File: rtl/id_stage_pipe.sv
// RV32I(+M) decode stage between IF and EX: combinational decode into a packed
// control word, followed by a 1- or 2-entry in-order output buffer with valid/ready and flush.
module id_stage_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1,
    parameter bit          OUT_SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [27:0]     out_ctrl
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [27:0]     ctrl;
    } entry_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = 5'd0;
            3'b001:  base_alu = 5'd7;
            3'b010:  base_alu = 5'd5;
            3'b011:  base_alu = 5'd6;
            3'b100:  base_alu = 5'd4;
            3'b101:  base_alu = 5'd8;
            3'b110:  base_alu = 5'd3;
            default: base_alu = 5'd2;
        endcase
    endfunction

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  alu_op;
    logic [2:0]  imm_type, br_op;
    logic [1:0]  wb_sel, mem_size;
    logic        reg_write, mem_read, mem_write, branch, jal, jalr, rs2_imm, pc_add;
    logic        mem_uns, illegal, ecall, ebreak, muldiv;
    logic [27:0] dec_ctrl;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];

    always_comb begin
        alu_op    = '0;
        imm_type  = '0;
        br_op     = '0;
        wb_sel    = '0;
        mem_size  = '0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jal       = 1'b0;
        jalr      = 1'b0;
        rs2_imm   = 1'b0;
        pc_add    = 1'b0;
        mem_uns   = 1'b0;
        illegal   = 1'b0;
        ecall     = 1'b0;
        ebreak    = 1'b0;
        muldiv    = 1'b0;
        if (opc[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opc)
                OPC_LUI: begin
                    imm_type  = 3'd3;
                    wb_sel    = 2'd3;
                    reg_write = 1'b1;
                end
                OPC_AUIPC: begin
                    imm_type  = 3'd3;
                    pc_add    = 1'b1;
                    rs2_imm   = 1'b1;
                    reg_write = 1'b1;
                end
                OPC_JAL: begin
                    imm_type  = 3'd4;
                    wb_sel    = 2'd2;
                    jal       = 1'b1;
                    reg_write = 1'b1;
                end
                OPC_JALR: begin
                    illegal   = (f3 != 3'b000);
                    wb_sel    = 2'd2;
                    jalr      = 1'b1;
                    rs2_imm   = 1'b1;
                    reg_write = 1'b1;
                end
                OPC_BRANCH: begin
                    illegal  = (f3 == 3'b010) || (f3 == 3'b011);
                    imm_type = 3'd2;
                    alu_op   = 5'd1;
                    br_op    = f3;
                    branch   = 1'b1;
                end
                OPC_LOAD: begin
                    illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                    mem_read  = 1'b1;
                    wb_sel    = 2'd1;
                    rs2_imm   = 1'b1;
                    reg_write = 1'b1;
                    mem_size  = f3[1:0];
                    mem_uns   = f3[2];
                end
                OPC_STORE: begin
                    illegal   = (f3 >= 3'b011);
                    imm_type  = 3'd1;
                    mem_write = 1'b1;
                    rs2_imm   = 1'b1;
                    mem_size  = f3[1:0];
                end
                OPC_OPIMM: begin
                    rs2_imm   = 1'b1;
                    reg_write = 1'b1;
                    alu_op    = base_alu(f3);
                    if (f3 == 3'b001) begin
                        illegal = (f7 != 7'b0000000);
                    end else if (f3 == 3'b101) begin
                        if (f7 == 7'b0100000) alu_op = 5'd9;
                        else if (f7 != 7'b0000000) illegal = 1'b1;
                    end
                end
                OPC_OP: begin
                    reg_write = 1'b1;
                    if (f7 == 7'b0000000) begin
                        alu_op = base_alu(f3);
                    end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                        alu_op = 5'd1;
                    end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                        alu_op = 5'd9;
                    end else if (f7 == 7'b0000001 && ENABLE_M) begin
                        alu_op = 5'd10 + {2'b00, f3};
                        muldiv = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OPC_FENCE: ;
                OPC_SYSTEM: begin
                    if (in_inst == 32'h0000_0073)      ecall   = 1'b1;
                    else if (in_inst == 32'h0010_0073) ebreak  = 1'b1;
                    else                               illegal = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end

        dec_ctrl = {muldiv, ebreak, ecall, 1'b0, mem_uns, mem_size, pc_add, rs2_imm,
                    jalr, jal, branch, mem_write, mem_read,
                    reg_write && (in_inst[11:7] != 5'd0),
                    wb_sel, br_op, imm_type, alu_op};
        // An illegal encoding carries only the illegal flag so EX never acts on stray bits
        if (illegal) dec_ctrl = 28'h100_0000;
    end

    state_t state_q, state_d;
    entry_t head_q, head_d, tail_q, tail_d, new_e;
    logic   push, pop;

    assign new_e = '{pc: in_pc, rs1: in_inst[19:15], rs2: in_inst[24:20], rd: in_inst[11:7],
                     funct3: f3, ctrl: dec_ctrl};

    // OUT_SKID=0 never reaches ST_TWO because in_ready then requires a pop whenever ONE
    assign in_ready  = OUT_SKID ? (state_q != ST_TWO) : ((state_q == ST_EMPTY) || out_ready);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) begin
                    head_d  = new_e;
                    state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d = new_e;
                    end else if (push) begin
                        tail_d  = new_e;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign out_pc     = head_q.pc;
    assign out_rs1    = head_q.rs1;
    assign out_rs2    = head_q.rs2;
    assign out_rd     = head_q.rd;
    assign out_funct3 = head_q.funct3;
    assign out_ctrl   = head_q.ctrl;

endmodule
